// File: rtl/sdu_pkg.sv
// Shared definitions for the SDU UART receive path: parity modes, FSM encoding
// and the baud-tick divider computation.
package sdu_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StPar,
        StStop,
        StBreak
    } rx_state_e;

    // Rounded clk cycles per oversample tick.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned os);
        logic [63:0] den;
        den = 64'(baud) * 64'(os);
        return 32'((64'(clk_hz) + den / 64'd2) / den);
    endfunction

endpackage

// File: rtl/sdu_uart_rx_if.sv
// Bus between the UART receiver (slave) and the SDU command decoder (master):
// serial line in, FIFO read port and sticky error flags out.
interface sdu_uart_rx_if #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 16
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic                 rxd;
    logic                 rd_en;
    logic                 clr_err;
    logic [DATA_BITS-1:0] dout;
    logic                 empty;
    logic                 full;
    logic [CW-1:0]        count;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;

    modport slave (
        input  rxd, rd_en, clr_err,
        output dout, empty, full, count, frame_err, parity_err, overrun
    );

    modport master (
        output rxd, rd_en, clr_err,
        input  dout, empty, full, count, frame_err, parity_err, overrun
    );

endinterface

// File: rtl/sdu_sync_fifo.sv
// Single-clock show-ahead FIFO; rdata always shows the head word. A push while
// full only succeeds if a pop happens in the same cycle.
module sdu_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));
    assign count = cnt_q;
    assign rdata = mem_q[rptr_q];

    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/sdu_uart_rx.sv
// UART receiver for the serial debug unit: synchroniser, oversample tick
// generator, frame decoder FSM, receive FIFO and sticky error flags.
module sdu_uart_rx
    import sdu_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input logic           clk,
    input logic           rstn,
    sdu_uart_rx_if.slave  bus
);
    localparam int unsigned DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned PW  = $clog2(OVERSAMPLE);
    localparam int unsigned BW  = $clog2(DATA_BITS);
    localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [PW-1:0] PH_S0    = PW'(OVERSAMPLE / 2 - 1);
    localparam logic [PW-1:0] PH_S1    = PW'(OVERSAMPLE / 2);
    localparam logic [PW-1:0] PH_S2    = PW'(OVERSAMPLE / 2 + 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    if (DIV < 1) begin : g_bad_div
        $error("sdu_uart_rx: CLK_HZ too low for BAUD*OVERSAMPLE");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
        $error("sdu_uart_rx: OVERSAMPLE must be even and >= 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY > PAR_EVEN) begin : g_bad_fmt
        $error("sdu_uart_rx: unsupported frame format");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sdu_uart_rx: FIFO_DEPTH must be a power of two >= 2");
    end

    rx_state_e            state_q, state_d;
    logic [1:0]           sync_q;
    logic                 rxs;
    logic                 prev_q;
    logic [2:0]           warm_q;
    logic                 fall;
    logic [DW-1:0]        div_q;
    logic                 tick;
    logic [PW-1:0]        ph_q;
    logic                 s0_q, s1_q;
    logic                 samp_now;
    logic                 maj;
    logic [BW-1:0]        bit_q;
    logic [DATA_BITS-1:0] sh_q;
    logic                 bad_q;
    logic                 par_exp;
    logic                 start_clr;
    logic                 push;
    logic                 par_evt;
    logic                 frame_evt;
    logic                 ovr_evt;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_dout;
    logic [CW-1:0]        fifo_count;
    logic                 frame_err_q, parity_err_q, overrun_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
            warm_q <= '0;
        end else begin
            sync_q <= {sync_q[0], bus.rxd};
            prev_q <= rxs;
            warm_q <= {warm_q[1:0], 1'b1};
        end
    end

    assign rxs = sync_q[1];
    // Ignore edges until the synchroniser's reset-time highs have flushed out,
    // so a line held low through reset never looks like a start bit.
    assign fall = warm_q[2] & prev_q & ~rxs;

    assign tick     = (div_q == DIV_LAST);
    assign samp_now = tick && (ph_q == PH_S2);
    assign maj      = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);
    assign par_exp  = (PARITY == PAR_ODD) ? ~(^sh_q) : ^sh_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_q <= '0;
            ph_q  <= '0;
            s0_q  <= 1'b1;
            s1_q  <= 1'b1;
            bit_q <= '0;
            sh_q  <= '0;
            bad_q <= 1'b0;
        end else if (start_clr) begin
            div_q <= '0;
            ph_q  <= '0;
            bit_q <= '0;
            bad_q <= 1'b0;
        end else begin
            div_q <= tick ? '0 : div_q + 1'b1;
            if (tick) begin
                ph_q <= (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
            end
            if (tick && ph_q == PH_S0) begin
                s0_q <= rxs;
            end
            if (tick && ph_q == PH_S1) begin
                s1_q <= rxs;
            end
            if (samp_now && state_q == StData) begin
                sh_q  <= {maj, sh_q[DATA_BITS-1:1]};
                bit_q <= bit_q + 1'b1;
            end
            if (par_evt) begin
                bad_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (fall) state_d = StStart;
            StStart: if (samp_now) state_d = maj ? StIdle : StData;
            StData: begin
                if (samp_now && bit_q == BIT_LAST) begin
                    state_d = (PARITY != PAR_NONE) ? StPar : StStop;
                end
            end
            StPar:   if (samp_now) state_d = StStop;
            StStop:  if (samp_now) state_d = maj ? StIdle : StBreak;
            StBreak: if (rxs) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        start_clr = 1'b0;
        push      = 1'b0;
        par_evt   = 1'b0;
        frame_evt = 1'b0;
        unique case (state_q)
            StIdle: start_clr = fall;
            StPar:  par_evt   = samp_now && (maj != par_exp);
            StStop: begin
                push      = samp_now & maj & ~bad_q;
                frame_evt = samp_now & ~maj;
            end
            default: ;
        endcase
    end

    // Full implies non-empty, so a same-cycle rd_en always makes room.
    assign ovr_evt = push & fifo_full & ~bus.rd_en;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_err_q  <= (frame_err_q & ~bus.clr_err) | frame_evt;
            parity_err_q <= (parity_err_q & ~bus.clr_err) | par_evt;
            overrun_q    <= (overrun_q & ~bus.clr_err) | ovr_evt;
        end
    end

    sdu_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .wdata (sh_q),
        .pop   (bus.rd_en),
        .rdata (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign bus.dout       = fifo_dout;
    assign bus.empty      = fifo_empty;
    assign bus.full       = fifo_full;
    assign bus.count      = fifo_count;
    assign bus.frame_err  = frame_err_q;
    assign bus.parity_err = parity_err_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_sdu_uart_rx.sv
// Directed bench for sdu_uart_rx: three receivers (8N1/16, 8E1/16, 8N1/4) on a
// 16 MHz clock at 1 Mbaud, so one bit lasts 16 clk.
module tb_sdu_uart_rx;
    localparam int unsigned CLK_HZ   = 16_000_000;
    localparam int unsigned BAUD     = 1_000_000;
    localparam int unsigned OS       = 16;
    localparam int          BIT_CLKS = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    sdu_uart_rx_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if_a ();
    sdu_uart_rx_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if_p ();
    sdu_uart_rx_if #(.DATA_BITS(8), .FIFO_DEPTH(4))  if_f ();

    sdu_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0),
                  .FIFO_DEPTH(16)) u_a (.clk(clk), .rstn(rstn), .bus(if_a));
    sdu_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(2),
                  .FIFO_DEPTH(16)) u_p (.clk(clk), .rstn(rstn), .bus(if_p));
    sdu_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0),
                  .FIFO_DEPTH(4)) u_f (.clk(clk), .rstn(rstn), .bus(if_f));

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_line(input int sel, input logic v);
        case (sel)
            0:       if_a.rxd = v;
            1:       if_p.rxd = v;
            default: if_f.rxd = v;
        endcase
    endtask

    task automatic send_bit(input int sel, input logic v);
        set_line(sel, v);
        idle(BIT_CLKS);
    endtask

    // Start, 8 data bits LSB first, optional parity, stop; line left at stop level.
    task automatic send_frame(input int sel, input logic [7:0] d, input bit use_par,
                              input logic par_bit, input logic stop_bit);
        send_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
        if (use_par) send_bit(sel, par_bit);
        send_bit(sel, stop_bit);
    endtask

    task automatic pop(input int sel);
        case (sel)
            0:       if_a.rd_en = 1'b1;
            1:       if_p.rd_en = 1'b1;
            default: if_f.rd_en = 1'b1;
        endcase
        idle(1);
        if_a.rd_en = 1'b0;
        if_p.rd_en = 1'b0;
        if_f.rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        if_a.clr_err = 1'b1;
        if_p.clr_err = 1'b1;
        if_f.clr_err = 1'b1;
        idle(1);
        if_a.clr_err = 1'b0;
        if_p.clr_err = 1'b0;
        if_f.clr_err = 1'b0;
        idle(1);
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) set_line(s, 1'b0);
        if_a.rd_en = 0; if_p.rd_en = 0; if_f.rd_en = 0;
        if_a.clr_err = 0; if_p.clr_err = 0; if_f.clr_err = 0;
        rstn = 1'b0;
        idle(3);
        n_tests++; if (if_a.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", if_a.empty); end
        n_tests++; if (if_a.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", if_a.full); end
        n_tests++; if (if_a.count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", if_a.count); end
        n_tests++; if (if_a.dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", if_a.dout); end
        n_tests++; if (if_a.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", if_a.frame_err); end
        n_tests++; if (if_a.parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err: got %b want 0", if_a.parity_err); end
        n_tests++; if (if_a.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", if_a.overrun); end
        // Line low across reset release must not be taken as a start bit.
        rstn = 1'b1;
        idle(30);
        for (int s = 0; s < 3; s++) set_line(s, 1'b1);
        idle(200);
        n_tests++; if (if_a.empty !== 1'b1) begin n_fail++; $display("FAIL arm_low_reset_empty: got %b want 1", if_a.empty); end
        n_tests++; if (if_a.frame_err !== 1'b0) begin n_fail++; $display("FAIL arm_low_reset_frame_err: got %b want 0", if_a.frame_err); end
    endtask

    task automatic test_basic_frame();
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        set_line(0, 1'b1);
        idle(4);
        n_tests++; if (if_a.dout !== 8'hA5) begin n_fail++; $display("FAIL basic_dout: got %h want a5", if_a.dout); end
        n_tests++; if (if_a.count !== 5'd1) begin n_fail++; $display("FAIL basic_count: got %0d want 1", if_a.count); end
        n_tests++; if (if_a.empty !== 1'b0) begin n_fail++; $display("FAIL basic_empty: got %b want 0", if_a.empty); end
        n_tests++; if ({if_a.frame_err, if_a.parity_err, if_a.overrun} !== 3'b000) begin
            n_fail++; $display("FAIL basic_flags: got %b want 000", {if_a.frame_err, if_a.parity_err, if_a.overrun}); end
        pop(0);
        n_tests++; if (if_a.empty !== 1'b1) begin n_fail++; $display("FAIL basic_pop_empty: got %b want 1", if_a.empty); end
        n_tests++; if (if_a.count !== 5'd0) begin n_fail++; $display("FAIL basic_pop_count: got %0d want 0", if_a.count); end
    endtask

    task automatic test_parity();
        // 0x3C has four ones: even parity bit is 0, so 1 is a mismatch.
        send_frame(1, 8'h3C, 1'b1, 1'b1, 1'b1);
        set_line(1, 1'b1);
        idle(4);
        n_tests++; if (if_p.parity_err !== 1'b1) begin n_fail++; $display("FAIL par_err_set: got %b want 1", if_p.parity_err); end
        n_tests++; if (if_p.empty !== 1'b1) begin n_fail++; $display("FAIL par_discard_empty: got %b want 1", if_p.empty); end
        n_tests++; if (if_p.frame_err !== 1'b0) begin n_fail++; $display("FAIL par_frame_err: got %b want 0", if_p.frame_err); end
        pulse_clr();
        n_tests++; if (if_p.parity_err !== 1'b0) begin n_fail++; $display("FAIL par_err_clr: got %b want 0", if_p.parity_err); end
        send_frame(1, 8'h3C, 1'b1, 1'b0, 1'b1);
        set_line(1, 1'b1);
        idle(4);
        n_tests++; if (if_p.dout !== 8'h3C) begin n_fail++; $display("FAIL par_good_dout: got %h want 3c", if_p.dout); end
        n_tests++; if (if_p.parity_err !== 1'b0) begin n_fail++; $display("FAIL par_good_flag: got %b want 0", if_p.parity_err); end
        pop(1);
    endtask

    task automatic test_frame_err();
        send_frame(0, 8'h80, 1'b0, 1'b0, 1'b0);
        idle(40);
        n_tests++; if (if_a.frame_err !== 1'b1) begin n_fail++; $display("FAIL frm_err_set: got %b want 1", if_a.frame_err); end
        n_tests++; if (if_a.empty !== 1'b1) begin n_fail++; $display("FAIL frm_discard_empty: got %b want 1", if_a.empty); end
        set_line(0, 1'b1);
        idle(20);
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
        set_line(0, 1'b1);
        idle(4);
        n_tests++; if (if_a.dout !== 8'h11) begin n_fail++; $display("FAIL frm_next_dout: got %h want 11", if_a.dout); end
        n_tests++; if (if_a.count !== 5'd1) begin n_fail++; $display("FAIL frm_next_count: got %0d want 1", if_a.count); end
        n_tests++; if (if_a.frame_err !== 1'b1) begin n_fail++; $display("FAIL frm_err_sticky: got %b want 1", if_a.frame_err); end
        pop(0);
        pulse_clr();
        n_tests++; if (if_a.frame_err !== 1'b0) begin n_fail++; $display("FAIL frm_err_clr: got %b want 0", if_a.frame_err); end
    endtask

    task automatic test_overrun();
        for (int k = 1; k <= 5; k++) send_frame(2, 8'(k), 1'b0, 1'b0, 1'b1);
        set_line(2, 1'b1);
        idle(4);
        n_tests++; if (if_f.full !== 1'b1) begin n_fail++; $display("FAIL ovr_full: got %b want 1", if_f.full); end
        n_tests++; if (if_f.count !== 3'd4) begin n_fail++; $display("FAIL ovr_count: got %0d want 4", if_f.count); end
        n_tests++; if (if_f.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b want 1", if_f.overrun); end
        for (int k = 1; k <= 4; k++) begin
            n_tests++;
            if (if_f.dout !== 8'(k)) begin n_fail++; $display("FAIL ovr_dout_%0d: got %h want %h", k, if_f.dout, 8'(k)); end
            pop(2);
        end
        n_tests++; if (if_f.empty !== 1'b1) begin n_fail++; $display("FAIL ovr_drained: got %b want 1", if_f.empty); end
        pulse_clr();
        n_tests++; if (if_f.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clr: got %b want 0", if_f.overrun); end
    endtask

    task automatic test_glitch();
        set_line(0, 1'b0);
        idle(3);
        set_line(0, 1'b1);
        idle(40);
        n_tests++; if (if_a.empty !== 1'b1) begin n_fail++; $display("FAIL glitch_empty: got %b want 1", if_a.empty); end
        n_tests++; if (if_a.frame_err !== 1'b0) begin n_fail++; $display("FAIL glitch_frame_err: got %b want 0", if_a.frame_err); end
        send_frame(0, 8'h69, 1'b0, 1'b0, 1'b1);
        set_line(0, 1'b1);
        idle(4);
        n_tests++; if (if_a.dout !== 8'h69) begin n_fail++; $display("FAIL glitch_next_dout: got %h want 69", if_a.dout); end
        pop(0);
    endtask

    task automatic test_reset_mid();
        send_frame(0, 8'h77, 1'b0, 1'b0, 1'b1);
        set_line(0, 1'b1);
        idle(4);
        n_tests++; if (if_a.count !== 5'd1) begin n_fail++; $display("FAIL rmid_pre_count: got %0d want 1", if_a.count); end
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        send_bit(0, 1'b1);
        send_bit(0, 1'b0);
        set_line(0, 1'b1);
        rstn = 1'b0;
        idle(3);
        n_tests++; if (if_a.empty !== 1'b1) begin n_fail++; $display("FAIL rmid_empty: got %b want 1", if_a.empty); end
        n_tests++; if (if_a.count !== 5'd0) begin n_fail++; $display("FAIL rmid_count: got %0d want 0", if_a.count); end
        n_tests++; if (if_a.dout !== 8'h00) begin n_fail++; $display("FAIL rmid_dout: got %h want 00", if_a.dout); end
        rstn = 1'b1;
        idle(20);
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
        set_line(0, 1'b1);
        idle(4);
        n_tests++; if (if_a.dout !== 8'h5A) begin n_fail++; $display("FAIL rmid_next_dout: got %h want 5a", if_a.dout); end
        n_tests++; if (if_a.count !== 5'd1) begin n_fail++; $display("FAIL rmid_next_count: got %0d want 1", if_a.count); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_frame();
        test_parity();
        test_frame_err();
        test_overrun();
        test_glitch();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
